// File: rtl/otter_bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : otter_bp_pkg
// Description : Shared types for the OTTER branch predictor: RISC-V opcode
//               and funct3 encodings, the redirect-cause code driven on
//               pc_src, the kind of control transfer held in a BTB entry,
//               and the fetch step.
// Revision    : 1.0 - initial release
// ============================================================================
package otter_bp_pkg;

    localparam int PC_STEP = 4;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_branch_t;

    typedef enum logic [2:0] {
        F3_PRIV  = 3'b000,   // ecall/ebreak/mret group; treated as mret here
        F3_CSRRW = 3'b001,
        F3_CSRRS = 3'b010,
        F3_CSRRC = 3'b011
    } funct3_system_t;

    typedef enum logic [2:0] {
        PC_SRC_NONE   = 3'd0,
        PC_SRC_JALR   = 3'd1,
        PC_SRC_BRANCH = 3'd2,
        PC_SRC_JAL    = 3'd3,
        PC_SRC_INT    = 3'd4,
        PC_SRC_MRET   = 3'd5
    } pc_src_t;

    // Kind of control transfer cached in a BTB entry. Jumps always predict
    // taken on a hit; only branches consult the saturating counter.
    typedef enum logic [1:0] {
        BTB_BRANCH = 2'd0,
        BTB_JAL    = 2'd1,
        BTB_JALR   = 2'd2
    } btb_kind_t;

endpackage
`default_nettype wire

// File: rtl/otter_branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : otter_branch_predictor_if
// Description : Bundle between the OTTER pipeline (master) and the branch
//               predictor (slave).
//   IF  side : if_pc -> pred_taken, pred_target
//   EX  side : ex_valid, stall, ex_opcode, ex_func3, ex_pc, ex_rs1, ex_rs2,
//              ex_i_type, ex_b_type, ex_j_type, ex_pred_taken, ex_pred_tgt,
//              mepc, int_taken
//   Outputs  : flush, redirect_pc, pc_src (registered), stat_br, stat_miss
// Revision    : 1.0 - initial release
// ============================================================================
interface otter_branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    logic            ex_valid;
    logic            stall;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_func3;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1;
    logic [XLEN-1:0] ex_rs2;
    logic [XLEN-1:0] ex_i_type;
    logic [XLEN-1:0] ex_b_type;
    logic [XLEN-1:0] ex_j_type;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_tgt;
    logic [XLEN-1:0] mepc;
    logic            int_taken;

    logic            flush;
    logic [XLEN-1:0] redirect_pc;
    logic [2:0]      pc_src;
    logic [31:0]     stat_br;
    logic [31:0]     stat_miss;

    modport master (
        output if_pc, ex_valid, stall, ex_opcode, ex_func3, ex_pc, ex_rs1,
               ex_rs2, ex_i_type, ex_b_type, ex_j_type, ex_pred_taken,
               ex_pred_tgt, mepc, int_taken,
        input  pred_taken, pred_target, flush, redirect_pc, pc_src,
               stat_br, stat_miss
    );

    modport slave (
        input  if_pc, ex_valid, stall, ex_opcode, ex_func3, ex_pc, ex_rs1,
               ex_rs2, ex_i_type, ex_b_type, ex_j_type, ex_pred_taken,
               ex_pred_tgt, mepc, int_taken,
        output pred_taken, pred_target, flush, redirect_pc, pc_src,
               stat_br, stat_miss
    );
endinterface
`default_nettype wire

// File: rtl/otter_branch_cond.sv
`default_nettype none
// ============================================================================
// Module      : otter_branch_cond
// Description : Combinational RISC-V branch comparator.
//   i_rs1, i_rs2 : operands
//   i_func3      : branch funct3 (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   o_taken      : condition true; reserved funct3 codes give 0
// Revision    : 1.0 - initial release
// ============================================================================
module otter_branch_cond
    import otter_bp_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_func3,
    output logic            o_taken
);
    always_comb begin
        o_taken = 1'b0;
        case (i_func3)
            F3_BEQ:  o_taken = (i_rs1 == i_rs2);
            F3_BNE:  o_taken = (i_rs1 != i_rs2);
            F3_BLT:  o_taken = ($signed(i_rs1) <  $signed(i_rs2));
            F3_BGE:  o_taken = ($signed(i_rs1) >= $signed(i_rs2));
            F3_BLTU: o_taken = (i_rs1 <  i_rs2);
            F3_BGEU: o_taken = (i_rs1 >= i_rs2);
            default: o_taken = 1'b0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/otter_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : otter_branch_predictor
// Description : Direct-mapped BTB with saturating counters. Predicts in IF,
//               resolves BRANCH/JAL/JALR/mret/interrupt in EX and registers a
//               one-cycle flush with the corrected PC on a mispredict.
//   clk, rst_n : clock, asynchronous active-low reset
//   bp         : otter_branch_predictor_if.slave (IF lookup, EX resolve,
//                flush/redirect_pc/pc_src, stat_br/stat_miss)
//   Build option BP_STATS_EN: when defined, stat_br counts resolved
//   BRANCH/JAL/JALR and stat_miss their mispredicts (both saturating);
//   otherwise both read as constant zero.
// Revision    : 1.0 - initial release
// ============================================================================
module otter_branch_predictor
    import otter_bp_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BTB_DEPTH = 16,
    parameter int CTR_BITS  = 2
) (
    input  logic clk,
    input  logic rst_n,
    otter_branch_predictor_if.slave bp
);
    localparam int c_idx_w = $clog2(BTB_DEPTH);
    localparam int c_tag_w = XLEN - c_idx_w - 2;
    localparam logic [CTR_BITS-1:0] c_ctr_max  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] c_ctr_weak = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [XLEN-1:0]     c_step     = XLEN'(PC_STEP);

    // Entry widths depend on the instance parameters, so the struct lives here.
    typedef struct packed {
        logic                valid;
        logic [c_tag_w-1:0]  tag;
        btb_kind_t           kind;
        logic [XLEN-1:0]     target;
        logic [CTR_BITS-1:0] ctr;
    } btb_entry_t;

    btb_entry_t r_btb [BTB_DEPTH];

    // ------------------------------------------------------------------
    // IF lookup (reads registered state only, so a same-cycle update to the
    // same index is seen next cycle)
    // ------------------------------------------------------------------
    logic [c_idx_w-1:0] w_if_idx;
    logic [c_tag_w-1:0] w_if_tag;
    btb_entry_t         w_if_entry;
    logic               w_if_hit;

    assign w_if_idx   = bp.if_pc[c_idx_w+1:2];
    assign w_if_tag   = bp.if_pc[XLEN-1:c_idx_w+2];
    assign w_if_entry = r_btb[w_if_idx];
    assign w_if_hit   = w_if_entry.valid && (w_if_entry.tag == w_if_tag);

    assign bp.pred_taken  = w_if_hit &&
                            ((w_if_entry.kind != BTB_BRANCH) || w_if_entry.ctr[CTR_BITS-1]);
    assign bp.pred_target = w_if_hit ? w_if_entry.target : (bp.if_pc + c_step);

    // ------------------------------------------------------------------
    // EX resolution
    // ------------------------------------------------------------------
    logic            w_cond_taken;
    logic            w_act_taken;
    logic [XLEN-1:0] w_act_target;
    logic [XLEN-1:0] w_redirect;
    pc_src_t         w_cause;
    logic            w_btb_op;
    btb_kind_t       w_kind;
    logic            w_mispredict;
    logic            w_resolve;

    otter_branch_cond #(
        .XLEN (XLEN)
    ) u_cond (
        .i_rs1   (bp.ex_rs1),
        .i_rs2   (bp.ex_rs2),
        .i_func3 (bp.ex_func3),
        .o_taken (w_cond_taken)
    );

    always_comb begin
        w_act_taken  = 1'b0;
        w_act_target = bp.ex_pc + c_step;
        w_cause      = PC_SRC_NONE;
        w_btb_op     = 1'b0;
        w_kind       = BTB_BRANCH;
        case (bp.ex_opcode)
            OP_BRANCH: begin
                w_act_taken  = w_cond_taken;
                w_act_target = bp.ex_pc + bp.ex_b_type;
                w_cause      = PC_SRC_BRANCH;
                w_btb_op     = 1'b1;
                w_kind       = BTB_BRANCH;
            end
            OP_JAL: begin
                w_act_taken  = 1'b1;
                w_act_target = bp.ex_pc + bp.ex_j_type;
                w_cause      = PC_SRC_JAL;
                w_btb_op     = 1'b1;
                w_kind       = BTB_JAL;
            end
            OP_JALR: begin
                w_act_taken  = 1'b1;
                w_act_target = (bp.ex_rs1 + bp.ex_i_type) & ~c_ctr_lsb_mask();
                w_cause      = PC_SRC_JALR;
                w_btb_op     = 1'b1;
                w_kind       = BTB_JALR;
            end
            OP_SYSTEM: begin
                // mret returns through MEPC but is never cached in the BTB.
                if (bp.ex_func3 == F3_PRIV) begin
                    w_act_taken  = 1'b1;
                    w_act_target = bp.mepc;
                    w_cause      = PC_SRC_MRET;
                end
            end
            default: ;
        endcase
    end

    function automatic logic [XLEN-1:0] c_ctr_lsb_mask();
        return XLEN'(1);
    endfunction

    assign w_redirect   = w_act_taken ? w_act_target : (bp.ex_pc + c_step);
    assign w_mispredict = (w_act_taken != bp.ex_pred_taken) ||
                          (w_act_taken && bp.ex_pred_taken && (w_act_target != bp.ex_pred_tgt));
    // An accepted interrupt discards the EX instruction entirely.
    assign w_resolve    = bp.ex_valid && !bp.stall && !bp.int_taken;

    // ------------------------------------------------------------------
    // Registered flush / redirect
    // ------------------------------------------------------------------
    logic            r_flush;
    logic [XLEN-1:0] r_redirect_pc;
    pc_src_t         r_pc_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
            r_pc_src      <= PC_SRC_NONE;
        end else if (bp.int_taken) begin
            // Trap vector is chosen elsewhere; redirect_pc is left as is.
            r_flush  <= 1'b1;
            r_pc_src <= PC_SRC_INT;
        end else if (w_resolve && w_mispredict) begin
            r_flush       <= 1'b1;
            r_redirect_pc <= w_redirect;
            r_pc_src      <= w_cause;
        end else begin
            r_flush  <= 1'b0;
            r_pc_src <= PC_SRC_NONE;
        end
    end

    assign bp.flush       = r_flush;
    assign bp.redirect_pc = r_redirect_pc;
    assign bp.pc_src      = r_pc_src;

    // ------------------------------------------------------------------
    // BTB update, same edge as the flush register
    // ------------------------------------------------------------------
    logic [c_idx_w-1:0]  w_ex_idx;
    logic [c_tag_w-1:0]  w_ex_tag;
    logic                w_ex_hit;
    logic [CTR_BITS-1:0] w_ex_ctr;
    logic [CTR_BITS-1:0] w_ctr_next;
    logic                w_btb_we;
    btb_entry_t          w_new_entry;

    assign w_ex_idx = bp.ex_pc[c_idx_w+1:2];
    assign w_ex_tag = bp.ex_pc[XLEN-1:c_idx_w+2];
    assign w_ex_hit = r_btb[w_ex_idx].valid && (r_btb[w_ex_idx].tag == w_ex_tag);
    assign w_ex_ctr = r_btb[w_ex_idx].ctr;

    always_comb begin
        w_ctr_next = w_ex_ctr;
        if (w_act_taken) begin
            if (w_ex_ctr != c_ctr_max) w_ctr_next = w_ex_ctr + 1'b1;
        end else begin
            if (w_ex_ctr != '0) w_ctr_next = w_ex_ctr - 1'b1;
        end
    end

    // Hits always train; misses allocate only when taken so not-taken
    // branches never evict a useful entry.
    assign w_btb_we = w_resolve && w_btb_op && (w_ex_hit || w_act_taken);

    always_comb begin
        w_new_entry.valid  = 1'b1;
        w_new_entry.tag    = w_ex_tag;
        w_new_entry.kind   = w_kind;
        w_new_entry.target = w_act_target;
        w_new_entry.ctr    = w_ex_hit ? w_ctr_next : c_ctr_weak;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                r_btb[i] <= '0;
            end
        end else if (w_btb_we) begin
            r_btb[w_ex_idx] <= w_new_entry;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef BP_STATS_EN
    logic [31:0] r_stat_br;
    logic [31:0] r_stat_miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_br   <= '0;
            r_stat_miss <= '0;
        end else if (w_resolve && w_btb_op) begin
            if (r_stat_br != '1) r_stat_br <= r_stat_br + 32'd1;
            if (w_mispredict && (r_stat_miss != '1)) r_stat_miss <= r_stat_miss + 32'd1;
        end
    end

    assign bp.stat_br   = r_stat_br;
    assign bp.stat_miss = r_stat_miss;
`else
    assign bp.stat_br   = '0;
    assign bp.stat_miss = '0;
`endif

    // Byte-offset bits of word-aligned PCs carry no information here.
    logic w_unused;
    assign w_unused = &{1'b0, bp.if_pc[1:0], bp.ex_pc[1:0]};

endmodule
`default_nettype wire
